// File: rtl/trace_input_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dbg_arb_pkg
// Purpose  : Shared types, eof codes and helpers for the trace input arbiter.
// Revision : 1.0  initial release
// ============================================================================
package dbg_arb_pkg;

  // Arbiter state: free for round-robin pick, or held by one requester's frame
  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Per-beat eof codes; any nonzero code closes a frame
  localparam logic [1:0] EOF_NONE = 2'b00;
  localparam logic [1:0] EOF_LAST = 2'b11;

  // Width of a requester index (at least one bit)
  function automatic int id_width(input int req);
    return (req > 1) ? $clog2(req) : 1;
  endfunction

  // Next requester index with wrap to zero
  function automatic int wrap_inc(input int idx, input int req);
    return (idx + 1 >= req) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_input_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : trace_input_arbiter_if
// Purpose  : Tap-side request bus plus debugger-side trace input port.
// Revision : 1.0  initial release
// ============================================================================
interface trace_input_arbiter_if
  import dbg_arb_pkg::*;
#(
  parameter int N          = 16,
  parameter int DATA_WIDTH = 32,
  parameter int REQ        = 4
);

  localparam int IDW = id_width(REQ);

  // Requester side
  logic [REQ*N*DATA_WIDTH-1:0] req_vector;
  logic [REQ-1:0]              req_valid;
  logic [2*REQ-1:0]            req_eof;
  logic [REQ-1:0]              req_ready;

  // Debugger side
  logic                        ib_full;
  logic [N*DATA_WIDTH-1:0]     vector_out;
  logic                        enqueue;
  logic [1:0]                  eof_out;
  logic [IDW-1:0]              grant_id;
  logic                        locked;
  logic                        timeout_pulse;

  // Environment view: drives taps and buffer status, observes the arbiter
  modport master (
    output req_vector, req_valid, req_eof, ib_full,
    input  req_ready, vector_out, enqueue, eof_out, grant_id, locked, timeout_pulse
  );

  // Arbiter view
  modport slave (
    input  req_vector, req_valid, req_eof, ib_full,
    output req_ready, vector_out, enqueue, eof_out, grant_id, locked, timeout_pulse
  );

endinterface
`default_nettype wire

// File: rtl/trace_input_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Purpose  : Combinational rotate-priority encoder; first request at or above
//            the pointer wins, wrapping past the top index.
// Revision : 1.0  initial release
// ============================================================================
module rr_picker
  import dbg_arb_pkg::*;
#(
  parameter int REQ = 4
) (
  input  logic [REQ-1:0]          i_req,
  input  logic [id_width(REQ)-1:0] i_rr_ptr,
  output logic [REQ-1:0]          o_grant,
  output logic [id_width(REQ)-1:0] o_id,
  output logic                    o_any
);

  localparam int IDW = id_width(REQ);

  // One extra bit so pointer + offset never overflows before the wrap
  logic [IDW:0] w_idx;

  // Walk the requesters starting at the pointer and keep the first hit
  always_comb begin
    o_grant = '0;
    o_id    = '0;
    o_any   = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < REQ; k++) begin
      w_idx = {1'b0, i_rr_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(REQ)) begin
        w_idx = w_idx - (IDW+1)'(REQ);
      end
      if (!o_any && i_req[w_idx[IDW-1:0]]) begin
        o_grant[w_idx[IDW-1:0]] = 1'b1;
        o_id                    = w_idx[IDW-1:0];
        o_any                   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/trace_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : trace_input_arbiter
// Purpose  : Shares the debugger trace input among REQ taps. A grant is held
//            for a whole frame; an idle owner is evicted after a timeout.
// Revision : 1.0  initial release
// ============================================================================
module trace_input_arbiter
  import dbg_arb_pkg::*;
#(
  parameter int N          = 16,
  parameter int DATA_WIDTH = 32,
  parameter int REQ        = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  trace_input_arbiter_if.slave  bus
);

  localparam int IDW = id_width(REQ);
  localparam int VW  = N * DATA_WIDTH;
  localparam int CW  = $clog2(TIMEOUT);

  localparam logic [0:0]    c_S_IDLE   = ARB_IDLE;
  localparam logic [0:0]    c_S_LOCKED = ARB_LOCKED;
  // The threshold cycle is the idle cycle that would bring the count to TIMEOUT-1
  localparam logic [CW-1:0] c_CNT_LAST = CW'(TIMEOUT - 2);

  logic [0:0]     r_state;
  logic [IDW-1:0] r_owner;
  logic [IDW-1:0] r_rr_ptr;
  logic [CW-1:0]  r_idle_cnt;
  logic [VW-1:0]  r_vector;
  logic           r_enqueue;
  logic [1:0]     r_eof;
  logic [IDW-1:0] r_grant_id;
  logic           r_timeout;

  logic [REQ-1:0] w_pick_grant;
  logic [IDW-1:0] w_pick_id;
  logic           w_pick_any;
  logic [REQ-1:0] w_ready;
  logic [IDW-1:0] w_sel_id;
  logic           w_accept;
  logic [VW-1:0]  w_vec;
  logic [1:0]     w_eof;
  logic           w_last;
  logic           w_thresh;
  logic [IDW-1:0] w_owner_next;
  logic [IDW-1:0] w_sel_next;

  rr_picker #(
    .REQ      (REQ)
  ) u_picker (
    .i_req    (bus.req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_pick_grant),
    .o_id     (w_pick_id),
    .o_any    (w_pick_any)
  );

  // Ready and accepted-requester selection; everything stalls while reset or ib_full
  always_comb begin
    w_ready  = '0;
    w_sel_id = r_owner;
    w_accept = 1'b0;
    if (reset && !bus.ib_full) begin
      if (r_state == c_S_IDLE) begin
        w_ready  = w_pick_grant;
        w_sel_id = w_pick_id;
        w_accept = w_pick_any;
      end else begin
        w_ready[r_owner] = 1'b1;
        w_accept         = bus.req_valid[r_owner];
      end
    end
  end

  assign w_vec        = bus.req_vector[int'(w_sel_id)*VW +: VW];
  assign w_eof        = bus.req_eof[int'(w_sel_id)*2 +: 2];
  assign w_last       = ((w_eof & EOF_LAST) != EOF_NONE);
  // An accepted beat on the threshold cycle takes priority over the timeout
  assign w_thresh     = (r_state == c_S_LOCKED) && !w_accept && !bus.ib_full &&
                        (r_idle_cnt == c_CNT_LAST);
  assign w_owner_next = IDW'(wrap_inc(int'(r_owner), REQ));
  assign w_sel_next   = IDW'(wrap_inc(int'(w_sel_id), REQ));

  // Frame lock FSM, round-robin pointer and idle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= c_S_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (w_accept) begin
        r_idle_cnt <= '0;
        if (r_state == c_S_IDLE) begin
          if (w_last) begin
            r_rr_ptr <= w_sel_next;
          end else begin
            r_state <= c_S_LOCKED;
            r_owner <= w_sel_id;
          end
        end else if (w_last) begin
          r_state  <= c_S_IDLE;
          r_rr_ptr <= w_owner_next;
        end
      end else if (w_thresh) begin
        r_state    <= c_S_IDLE;
        r_rr_ptr   <= w_owner_next;
        r_idle_cnt <= '0;
        r_timeout  <= 1'b1;
      end else if ((r_state == c_S_LOCKED) && !bus.ib_full) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
    end
  end

  // Register the accepted beat toward the debugger input buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vector   <= '0;
      r_enqueue  <= 1'b0;
      r_eof      <= EOF_NONE;
      r_grant_id <= '0;
    end else begin
      r_enqueue <= w_accept;
      if (w_accept) begin
        r_vector   <= w_vec;
        r_eof      <= w_eof;
        r_grant_id <= w_sel_id;
      end
    end
  end

  assign bus.req_ready     = w_ready;
  assign bus.vector_out    = r_vector;
  assign bus.enqueue       = r_enqueue;
  assign bus.eof_out       = r_eof;
  assign bus.grant_id      = r_grant_id;
  assign bus.locked        = (r_state == c_S_LOCKED);
  assign bus.timeout_pulse = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_trace_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_input_arbiter
// Purpose  : Self-checking bench for trace_input_arbiter (REQ=4, TIMEOUT=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_trace_input_arbiter;
  import dbg_arb_pkg::*;

  localparam int N   = 2;
  localparam int DW  = 8;
  localparam int REQ = 4;
  localparam int TO  = 8;
  localparam int VW  = N * DW;

  typedef struct packed {
    logic [1:0]    id;
    logic [VW-1:0] vec;
    logic [1:0]    eof;
  } exp_t;

  typedef struct {
    logic [REQ-1:0] valid;
    logic [REQ-1:0] exp_ready;
    int             exp_id;
  } tv_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  exp_t          exp_q[$];
  exp_t          mon_e;
  tv_t           tv[12];
  logic [VW-1:0] src_vec[REQ][16];
  logic [1:0]    src_eof[REQ][16];
  int            src_len[REQ];
  int            src_pos[REQ];

  trace_input_arbiter_if #(.N(N), .DATA_WIDTH(DW), .REQ(REQ)) bus ();

  trace_input_arbiter #(
    .N(N), .DATA_WIDTH(DW), .REQ(REQ), .TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] vec_of(input int i, input int k);
    return VW'(i * 256 + k);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input int i, input logic [1:0] eof, input int k);
    src_vec[i][src_len[i]] = vec_of(i, k);
    src_eof[i][src_len[i]] = eof;
    src_len[i]++;
  endtask

  task automatic expect_beat(input int id, input int k, input logic [1:0] eof);
    exp_q.push_back(exp_t'{id: 2'(id), vec: vec_of(id, k), eof: eof});
  endtask

  task automatic drive();
    for (int i = 0; i < REQ; i++) begin
      if (src_pos[i] < src_len[i]) begin
        bus.req_valid[i]            = 1'b1;
        bus.req_vector[i*VW +: VW]  = src_vec[i][src_pos[i]];
        bus.req_eof[i*2 +: 2]       = src_eof[i][src_pos[i]];
      end else begin
        bus.req_valid[i]            = 1'b0;
        bus.req_vector[i*VW +: VW]  = '0;
        bus.req_eof[i*2 +: 2]       = 2'b00;
      end
    end
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < REQ; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
    drive();
  endtask

  // Called at a negedge: record handshakes, cross the rising edge, present next beats
  task automatic advance();
    logic [REQ-1:0] fire;
    fire = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < REQ; i++) begin
      if (fire[i]) src_pos[i]++;
    end
    drive();
  endtask

  task automatic cyc();
    @(negedge clk);
    advance();
  endtask

  task automatic drain(input string name, input int max_cycles);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < max_cycles) begin
      cyc();
      c++;
    end
    repeat (2) cyc();
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Scoreboard: every enqueue must match the next expected beat
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.enqueue === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_enqueue: got id %0d vec %0h eof %0b expected none at %0t",
                 bus.grant_id, bus.vector_out, bus.eof_out, $time);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.grant_id, bus.vector_out, bus.eof_out} !== mon_e) begin
          n_fail++;
          $display("FAIL beat: got id %0d vec %0h eof %0b expected id %0d vec %0h eof %0b at %0t",
                   bus.grant_id, bus.vector_out, bus.eof_out,
                   mon_e.id, mon_e.vec, mon_e.eof, $time);
        end
      end
    end
  end

  initial begin
    tv[0]  = '{4'b1111, 4'b0001, 0};
    tv[1]  = '{4'b1111, 4'b0010, 1};
    tv[2]  = '{4'b1111, 4'b0100, 2};
    tv[3]  = '{4'b1111, 4'b1000, 3};
    tv[4]  = '{4'b1111, 4'b0001, 0};
    tv[5]  = '{4'b0001, 4'b0001, 0};
    tv[6]  = '{4'b1001, 4'b1000, 3};
    tv[7]  = '{4'b0110, 4'b0010, 1};
    tv[8]  = '{4'b0000, 4'b0000, 0};
    tv[9]  = '{4'b0011, 4'b0001, 0};
    tv[10] = '{4'b1100, 4'b0100, 2};
    tv[11] = '{4'b0101, 4'b0001, 0};

    // Reset state, with every requester asking
    rst_n          = 1'b0;
    bus.ib_full    = 1'b0;
    bus.req_valid  = '1;
    bus.req_vector = '1;
    bus.req_eof    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",    32'(bus.req_ready), 32'h0);
    chk("rst_enqueue",  32'(bus.enqueue), 32'h0);
    chk("rst_vector",   32'(bus.vector_out), 32'h0);
    chk("rst_locked",   32'(bus.locked), 32'h0);
    chk("rst_timeout",  32'(bus.timeout_pulse), 32'h0);
    chk("rst_grant_id", 32'(bus.grant_id), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_srcs();

    // Round-robin over single-beat frames, table driven
    for (int r = 0; r < 12; r++) begin
      bus.req_valid = tv[r].valid;
      for (int i = 0; i < REQ; i++) bus.req_vector[i*VW +: VW] = vec_of(i, 100 + r);
      bus.req_eof = {REQ{2'b01}};
      @(negedge clk);
      chk("rr_ready", 32'(bus.req_ready), 32'(tv[r].exp_ready));
      chk("rr_locked", 32'(bus.locked), 32'h0);
      if (tv[r].exp_ready != '0) expect_beat(tv[r].exp_id, 100 + r, 2'b01);
      @(posedge clk);
      #1;
    end
    clear_srcs();
    drain("rr_drain", 10);

    // Frame lock: req1 owns a 3-beat frame while req0/req2 wait (pointer at 1)
    clear_srcs();
    add(1, 2'b00, 10); add(1, 2'b00, 11); add(1, 2'b10, 12);
    add(0, 2'b01, 13); add(2, 2'b01, 14);
    expect_beat(1, 10, 2'b00); expect_beat(1, 11, 2'b00); expect_beat(1, 12, 2'b10);
    expect_beat(2, 14, 2'b01); expect_beat(0, 13, 2'b01);
    drive();
    @(negedge clk); chk("lock_first_ready", 32'(bus.req_ready), 32'h2); advance();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("lock_locked", 32'(bus.locked), 32'h1);
      chk("lock_others_stalled", 32'(bus.req_ready & 4'b1101), 32'h0);
      advance();
    end
    @(negedge clk); chk("lock_release", 32'(bus.locked), 32'h0); advance();
    drain("lock_drain", 10);

    // Backpressure mid-frame: ib_full longer than the timeout, lock kept
    clear_srcs();
    add(2, 2'b00, 20); add(2, 2'b00, 21); add(2, 2'b00, 22); add(2, 2'b11, 23);
    add(0, 2'b01, 24);
    expect_beat(2, 20, 2'b00); expect_beat(2, 21, 2'b00); expect_beat(2, 22, 2'b00);
    expect_beat(2, 23, 2'b11); expect_beat(0, 24, 2'b01);
    drive();
    cyc(); cyc();
    bus.ib_full = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_ready", 32'(bus.req_ready), 32'h0);
      chk("bp_locked", 32'(bus.locked), 32'h1);
      chk("bp_no_timeout", 32'(bus.timeout_pulse), 32'h0);
      if (k > 0) chk("bp_no_enqueue", 32'(bus.enqueue), 32'h0);
      advance();
    end
    bus.ib_full = 1'b0;
    @(negedge clk);
    chk("bp_no_enqueue", 32'(bus.enqueue), 32'h0);
    chk("bp_resume_ready", 32'(bus.req_ready), 32'h4);
    advance();
    drain("bp_drain", 10);

    // Timeout: req3 goes silent after an eof=00 beat; req0 waits
    clear_srcs();
    add(3, 2'b00, 30); add(0, 2'b01, 31);
    expect_beat(3, 30, 2'b00); expect_beat(0, 31, 2'b01);
    drive();
    @(negedge clk); chk("to_first_ready", 32'(bus.req_ready), 32'h8); advance();
    for (int k = 1; k < TO; k++) begin
      @(negedge clk);
      chk("to_locked", 32'(bus.locked), 32'h1);
      chk("to_no_pulse", 32'(bus.timeout_pulse), 32'h0);
      chk("to_others_stalled", 32'(bus.req_ready & 4'b0111), 32'h0);
      advance();
    end
    @(negedge clk);
    chk("to_pulse", 32'(bus.timeout_pulse), 32'h1);
    chk("to_unlocked", 32'(bus.locked), 32'h0);
    chk("to_next_grant", 32'(bus.req_ready), 32'h1);
    advance();
    @(negedge clk); chk("to_pulse_once", 32'(bus.timeout_pulse), 32'h0); advance();
    drain("to_drain", 10);

    // Collision: owner's closing beat lands on the threshold cycle
    clear_srcs();
    add(1, 2'b00, 40);
    expect_beat(1, 40, 2'b00); expect_beat(1, 41, 2'b11);
    drive();
    @(negedge clk); chk("col_first_ready", 32'(bus.req_ready), 32'h2); advance();
    for (int k = 1; k < TO - 1; k++) begin
      @(negedge clk); chk("col_no_pulse", 32'(bus.timeout_pulse), 32'h0); advance();
    end
    add(1, 2'b11, 41);
    drive();
    @(negedge clk);
    chk("col_no_pulse", 32'(bus.timeout_pulse), 32'h0);
    chk("col_ready", 32'(bus.req_ready), 32'h2);
    advance();
    @(negedge clk);
    chk("col_no_pulse", 32'(bus.timeout_pulse), 32'h0);
    chk("col_release", 32'(bus.locked), 32'h0);
    chk("col_enqueue", 32'(bus.enqueue), 32'h1);
    advance();
    drain("col_drain", 10);

    // Reset mid-frame: req2 holds the lock when reset drops
    clear_srcs();
    add(2, 2'b00, 50); add(2, 2'b00, 51); add(2, 2'b00, 52);
    expect_beat(2, 50, 2'b00); expect_beat(2, 51, 2'b00);
    drive();
    cyc(); cyc();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_ready",    32'(bus.req_ready), 32'h0);
    chk("mrst_enqueue",  32'(bus.enqueue), 32'h0);
    chk("mrst_vector",   32'(bus.vector_out), 32'h0);
    chk("mrst_eof",      32'(bus.eof_out), 32'h0);
    chk("mrst_grant_id", 32'(bus.grant_id), 32'h0);
    chk("mrst_locked",   32'(bus.locked), 32'h0);
    chk("mrst_timeout",  32'(bus.timeout_pulse), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear_srcs();
    add(3, 2'b01, 61); add(1, 2'b01, 60);
    expect_beat(1, 60, 2'b01); expect_beat(3, 61, 2'b01);
    drive();
    rst_n = 1'b1;
    @(negedge clk); chk("mrst_first_grant", 32'(bus.req_ready), 32'h2); advance();
    drain("mrst_drain", 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trace_input_arbiter.md
# trace_input_arbiter

Shares the debugger's single trace input port (`vector_in`/`enqueue`/`eof_in`) between `REQ` independent tap points. Each tap streams N-lane vectors with a valid/ready handshake. A grant is held for a whole frame, from the first beat until a beat with nonzero eof, so frames never interleave in the input buffer. Sits directly in front of the debugger instance, between the design-under-debug taps and the debugger.

## Interface
Parameters:
- `N`, 16, vector lanes
- `DATA_WIDTH`, 32, bits per lane
- `REQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 64, idle cycles in LOCKED before the lock is forcibly released (≥2)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately
- `req_vector`  in  REQ·N·DATA_WIDTH  packed; requester i occupies slice i
- `req_valid`  in  REQ  beat offered by requester i
- `req_eof`  in  2·REQ  eof code per requester; 2'b00 = mid-frame, nonzero = last beat of frame
- `req_ready`  out  REQ  combinational; beat i accepted when `req_valid[i] && req_ready[i]`
- `ib_full`  in  1  debugger input buffer cannot take a beat this cycle
- `vector_out`  out  N·DATA_WIDTH  registered accepted vector
- `enqueue`  out  1  registered; one-cycle pulse per accepted beat
- `eof_out`  out  2  registered eof of the accepted beat
- `grant_id`  out  $clog2(REQ)  requester of the most recent accepted beat
- `locked`  out  1  high while in LOCKED
- `timeout_pulse`  out  1  one-cycle pulse on a forced release

## Operation
- State is one of IDLE or LOCKED; `owner` and `rr_ptr` are registers.
- **IDLE:**
  - Round-robin pick of the first `req_valid[i]`, searching from `rr_ptr` upward with wrap.
  - `req_ready` is high only for the picked requester, and only when `!ib_full`.
  - If the accepted beat has eof == 0: go to LOCKED, set `owner` = i.
  - If the accepted beat has eof != 0 (single-beat frame): stay in IDLE, set `rr_ptr` = i+1 mod REQ.
- **LOCKED:**
  - Only `req_ready[owner]` can be high, and only when `!ib_full`. All other requesters are stalled.
  - An accepted beat with eof != 0 sends the block to IDLE and sets `rr_ptr` = owner+1 mod REQ.
- **Idle counter (LOCKED only):**
  - Increments on each LOCKED cycle with no accepted beat and `ib_full` low. Cycles with `ib_full` high do not count.
  - Clears on any accepted beat.
  - When the counter reaches TIMEOUT-1: go to IDLE, set `rr_ptr` = owner+1, pulse `timeout_pulse`. No synthetic beat is emitted.
- **Simultaneous events:** an accepted beat in the same cycle as the timeout threshold wins. No timeout occurs, and the normal eof rules apply.
- **`ib_full`:** while high, all `req_ready` are low and no state changes except the counter hold. The lock is kept.
- **Reset, including mid-frame:** outputs return to reset values, state = IDLE, `rr_ptr` = 0, counter = 0. The partial frame is abandoned.
- **Reset values:** `vector_out` 0, `enqueue` 0, `eof_out` 2'b00, `grant_id` 0, `locked` 0, `timeout_pulse` 0, `req_ready` 0 while reset is asserted.

## Timing
- Acceptance in cycle t produces `enqueue`/`vector_out`/`eof_out`/`grant_id` valid in cycle t+1.
- `enqueue` is low in any cycle following a cycle with no acceptance.
- Throughput is one beat per cycle, including back-to-back frames of one owner.
- After a release in cycle t, a new arbitration occurs in cycle t+1. There is no dead cycle beyond that.
- `locked` reflects the registered state: it rises in the cycle after the first eof==0 acceptance and falls in the cycle after the releasing beat or timeout.
- `timeout_pulse` is asserted in the cycle after the threshold cycle, coincident with `locked` falling.
- `req_ready` depends combinationally on `req_valid`, state and `ib_full`. It does not depend combinationally on its own output.

## Structure
- Shared package `dbg_arb_pkg`:
  - state enum {IDLE, LOCKED}
  - eof constants EOF_NONE = 2'b00 and EOF_LAST = 2'b11
  - `$clog2`-based id width function
- Sub-module `rr_picker`:
  - Purely combinational rotate-priority encoder.
  - Inputs: REQ-bit request vector, `rr_ptr`.
  - Outputs: one-hot grant, encoded id, any-valid.
- The FSM, counter and output register live in `trace_input_arbiter`.

## Test plan
- **Round-robin, single-beat frames:** REQ=4, all valid, every eof=01 → `grant_id` sequence 0,1,2,3,0, one `enqueue` per cycle, `locked` stays 0.
- **Frame lock:** req1 sends 3 beats (eof 00,00,10) while req0 and req2 hold valid → outputs in order are req1×3, then req2 (`rr_ptr` = 2). No req0/req2 beat appears inside the frame.
- **Backpressure:** `ib_full` high for 5 cycles mid-frame → `req_ready` all 0, no `enqueue`, no timeout. The frame resumes with the same owner.
- **Timeout:** TIMEOUT=8, owner req3 goes silent after a beat with eof=00 → `timeout_pulse` high once, 8 cycles after the last acceptance. `locked` falls with it. req0 is granted next.
- **Collision:** owner's eof beat arrives exactly on the threshold cycle → beat is enqueued, no `timeout_pulse`.
- **Reset mid-frame:** `reset` dropped while LOCKED → all outputs 0 asynchronously. After release, the first grant goes to the lowest valid index from `rr_ptr` = 0.
